// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer
// Control FSM that walks one AES-128 encryption through the shared step units
// (SubBytes, ShiftRows, MixColumns, AddRoundKey). It owns the 128-bit state
// register and drives exactly one unit at a time over a single enable/done bus.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   start         request encryption of data_in (sampled only in IDLE)
//   data_in       plaintext, latched when start is accepted
//   ready         high while in IDLE
//   step_sel      0=SubBytes 1=ShiftRows 2=MixColumns 3=AddRoundKey
//   step_en       one-cycle enable to the selected unit
//   step_state    state register, presented to the selected unit
//   round_idx     current round 0..NUM_ROUNDS, for round-key selection
//   step_result   output of the selected unit
//   step_done     selected unit finished; step_result valid
//   data_out      ciphertext (always the state register; qualify with out_valid)
//   out_valid     result available
//   out_ready     consumer accepts data_out
//   err           one-cycle pulse when a step times out
//   dbg_state     current FSM state (0=IDLE 1=ISSUE 2=WAIT 3=DONE)
//
// Handshakes: start is a request accepted on any edge where ready=1 and
// start=1. The output side is valid/ready: data_out is held stable while
// out_valid=1 and the transfer completes on the edge where out_valid and
// out_ready are both high. The step bus is enable/done: step_en pulses for
// one cycle and the unit answers with step_done at any later cycle; step_sel,
// round_idx and step_state stay stable until that step_done is captured.
module aes_round_sequencer #(
    parameter int WORD_SIZE  = 8,
    parameter int ARRAY_SIZE = 16,
    parameter int NUM_ROUNDS = 10,
    parameter int TIMEOUT    = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [WORD_SIZE*ARRAY_SIZE-1:0] data_in,
    output logic                            ready,
    output logic [1:0]                      step_sel,
    output logic                            step_en,
    output logic [WORD_SIZE*ARRAY_SIZE-1:0] step_state,
    output logic [3:0]                      round_idx,
    input  logic [WORD_SIZE*ARRAY_SIZE-1:0] step_result,
    input  logic                            step_done,
    output logic [WORD_SIZE*ARRAY_SIZE-1:0] data_out,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            err,
    output logic [1:0]                      dbg_state
);

    localparam int SW = WORD_SIZE * ARRAY_SIZE;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] SEL_SB  = 2'd0;
    localparam logic [1:0] SEL_SR  = 2'd1;
    localparam logic [1:0] SEL_MC  = 2'd2;
    localparam logic [1:0] SEL_ARK = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } fsm_t;

    fsm_t           fsm_q, fsm_d;
    logic [SW-1:0]  state_q, state_d;
    logic [3:0]     round_q, round_d;
    logic [1:0]     sel_q, sel_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           err_q, err_d;
    logic           last_round;

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            round_q <= '0;
            sel_q   <= SEL_ARK;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
            sel_q   <= sel_d;
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic and step advancement.
    always_comb begin
        fsm_d      = fsm_q;
        state_d    = state_q;
        round_d    = round_q;
        sel_d      = sel_q;
        timer_d    = timer_q;
        err_d      = 1'b0;
        last_round = (round_q == 4'(NUM_ROUNDS));

        case (fsm_q)
            IDLE: begin
                if (start) begin
                    state_d = data_in;
                    round_d = '0;
                    sel_d   = SEL_ARK;
                    fsm_d   = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                fsm_d   = WAIT;
            end
            WAIT: begin
                // A done in the final timeout cycle still counts as success.
                if (step_done) begin
                    state_d = step_result;
                    fsm_d   = ISSUE;
                    case (sel_q)
                        SEL_SB:  sel_d = SEL_SR;
                        // The last round has no MixColumns.
                        SEL_SR:  sel_d = last_round ? SEL_ARK : SEL_MC;
                        SEL_MC:  sel_d = SEL_ARK;
                        default: begin
                            // AddRoundKey closes a round (round 0 is ARK only).
                            if (last_round) begin
                                fsm_d = DONE;
                            end else begin
                                round_d = round_q + 4'd1;
                                sel_d   = SEL_SB;
                            end
                        end
                    endcase
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    // TIMEOUT wait cycles elapsed: abort, keep the state register.
                    err_d = 1'b1;
                    fsm_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // Output decodes.
    always_comb begin
        ready      = (fsm_q == IDLE);
        step_en    = (fsm_q == ISSUE);
        out_valid  = (fsm_q == DONE);
        step_sel   = sel_q;
        round_idx  = round_q;
        step_state = state_q;
        data_out   = state_q;
        err        = err_q;
        dbg_state  = fsm_q;
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed testbench for aes_round_sequencer. A behavioural step unit answers
// each step_en either with real AES step functions (with a round-key schedule
// expanded from the FIPS-197 key) or with a dummy state+1 unit, after a
// configurable delay, optionally never answering a chosen step.
module tb_aes_round_sequencer;

    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] data_in = '0;
    logic         ready;
    logic [1:0]   step_sel;
    logic         step_en;
    logic [127:0] step_state;
    logic [3:0]   round_idx;
    logic [127:0] step_result = '0;
    logic         step_done = 1'b0;
    logic [127:0] data_out;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         err;
    logic [1:0]   dbg_state;

    always #5 clk = ~clk;

    aes_round_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .data_in    (data_in),
        .ready      (ready),
        .step_sel   (step_sel),
        .step_en    (step_en),
        .step_state (step_state),
        .round_idx  (round_idx),
        .step_result(step_result),
        .step_done  (step_done),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    // ---------------- AES reference functions ----------------
    logic [127:0] rk [0:10];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        // r = x^254, the multiplicative inverse in GF(2^8) (0 maps to 0).
        for (int k = 7; k >= 0; k--) begin
            r = gmul(r, r);
            if (k != 0) r = gmul(r, x);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    task automatic expand_key(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
                t = t ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- behavioural step unit + monitors ----------------
    int           unit_delay = 1;
    bit           dummy_mode = 1'b0;
    int           hang_step  = 0;
    bit           pending    = 1'b0;
    int           cnt        = 0;
    logic [127:0] res_hold   = '0;
    int           en_cnt     = 0;
    int           err_cnt    = 0;
    int           ov_rise    = 0;
    bit           ov_prev    = 1'b0;
    logic [5:0]   trace_q[$];

    always @(negedge clk) begin
        step_done = 1'b0;
        if (pending) begin
            if (cnt == 0) begin
                step_done   = 1'b1;
                step_result = res_hold;
                pending     = 1'b0;
            end else begin
                cnt--;
            end
        end
        if (rst) begin
            trace_q.delete();
            en_cnt  = 0;
            err_cnt = 0;
            ov_rise = 0;
        end else begin
            if (err) err_cnt++;
            if (out_valid && !ov_prev) ov_rise++;
            if (step_en) begin
                en_cnt++;
                trace_q.push_back({round_idx, step_sel});
                if (en_cnt != hang_step) begin
                    pending = 1'b1;
                    cnt     = unit_delay - 1;
                    if (dummy_mode) res_hold = step_state + 128'd1;
                    else case (step_sel)
                        2'd0:    res_hold = sub_bytes(step_state);
                        2'd1:    res_hold = shift_rows(step_state);
                        2'd2:    res_hold = mix_columns(step_state);
                        default: res_hold = step_state ^ rk[round_idx];
                    endcase
                end
            end
        end
        ov_prev = out_valid;
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [5:0] exp_q[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Pulses start in cycle 0 and returns the cycle index (start cycle = 0)
    // in which out_valid is first seen, or -1 if it never appears. A second
    // start with poke_data is pulsed in cycle poke_at when poke_at > 0.
    task automatic run_enc(input logic [127:0] d, input int max_cyc, input int poke_at,
                           input logic [127:0] poke_data, output int cyc);
        @(negedge clk);
        start   = 1'b1;
        data_in = d;
        cyc     = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            start = (i == poke_at);
            if (i == poke_at) data_in = poke_data;
            if (out_valid) begin
                cyc = i;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cyc;
        int n;
        int first_err;
        bit stable;
        int mc_last;
        logic [127:0] held;
        logic [127:0] d;

        expand_key(KEY);
        do_reset();

        // Reset values
        chk("rst_ready", 128'(ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_err", 128'(err), 128'd0);
        chk("rst_step_en", 128'(step_en), 128'd0);
        chk("rst_step_sel", 128'(step_sel), 128'd3);
        chk("rst_round_idx", 128'(round_idx), 128'd0);
        chk("rst_data_out", data_out, 128'd0);
        chk("rst_dbg_state", 128'(dbg_state), 128'd0);

        // FIPS-197 vector with single-cycle units, latency and backpressure
        dummy_mode = 1'b0; unit_delay = 1; hang_step = 0;
        run_enc(PT, 500, 0, '0, cyc);
        chk("fips_latency", 128'(cyc), 128'd81);
        chk("fips_ct", data_out, CT);
        held   = data_out;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (data_out !== held || out_valid !== 1'b1) stable = 1'b0;
        end
        chk("bp_stable", 128'(stable), 128'd1);
        @(posedge clk);
        chk("fips_en_count", 128'(en_cnt), 128'd40);
        release_result();
        chk("bp_valid_drop", 128'(out_valid), 128'd0);
        chk("bp_ready_back", 128'(ready), 128'd1);

        // Sequence check with dummy unit; a second start mid-run is ignored
        do_reset();
        dummy_mode = 1'b1;
        d = 128'h0000000000000000ffffffffffffffe0;
        run_enc(d, 500, 20, 128'h5555, cyc);
        chk("seq_latency", 128'(cyc), 128'd81);
        chk("seq_data_out", data_out, 128'h00000000000000010000000000000008);
        exp_q.delete();
        exp_q.push_back({4'd0, 2'd3});
        for (int r = 1; r <= 9; r++)
            for (int s = 0; s < 4; s++) exp_q.push_back({4'(r), 2'(s)});
        exp_q.push_back({4'd10, 2'd0});
        exp_q.push_back({4'd10, 2'd1});
        exp_q.push_back({4'd10, 2'd3});
        @(posedge clk);
        chk("seq_trace_len", 128'(trace_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < trace_q.size(); i++)
            chk($sformatf("seq_trace[%0d]", i), 128'(trace_q[i]), 128'(exp_q[i]));
        mc_last = 0;
        foreach (trace_q[i]) if (trace_q[i] == {4'd10, 2'd2}) mc_last++;
        chk("seq_no_mc_last_round", 128'(mc_last), 128'd0);
        release_result();
        repeat (100) @(negedge clk);
        @(posedge clk);
        chk("busy_one_result", 128'(ov_rise), 128'd1);

        // Timeout: step 5 never completes
        do_reset();
        dummy_mode = 1'b1; hang_step = 5;
        d = 128'h1000;
        @(negedge clk);
        start = 1'b1; data_in = d;
        n = 0;
        for (int i = 0; i < 100 && n < 5; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (step_en) n++;
        end
        chk("to_reached_step5", 128'(n), 128'd5);
        first_err = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (err) begin
                first_err = i;
                break;
            end
        end
        chk("to_err_cycle", 128'(first_err), 128'd17);
        chk("to_ready", 128'(ready), 128'd1);
        chk("to_state_kept", data_out, d + 128'd4);
        @(negedge clk);
        chk("to_err_pulse_width", 128'(err), 128'd0);
        repeat (20) @(negedge clk);
        @(posedge clk);
        chk("to_err_count", 128'(err_cnt), 128'd1);
        chk("to_no_out_valid", 128'(ov_rise), 128'd0);
        hang_step = 0;

        // Reset during round 5 WAIT; the late step_done must be ignored
        do_reset();
        dummy_mode = 1'b0; unit_delay = 3;
        @(negedge clk);
        start = 1'b1; data_in = PT;
        n = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (step_en && round_idx == 4'd5) begin
                n = 1;
                break;
            end
        end
        chk("rmo_reached_round5", 128'(n), 128'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rmo_ready", 128'(ready), 128'd1);
        chk("rmo_out_valid", 128'(out_valid), 128'd0);
        chk("rmo_round_idx", 128'(round_idx), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rmo_late_done_ignored", data_out, 128'd0);
        chk("rmo_still_idle", 128'(ready), 128'd1);
        unit_delay = 1;
        run_enc(PT, 500, 0, '0, cyc);
        chk("rmo_fresh_latency", 128'(cyc), 128'd81);
        chk("rmo_fresh_ct", data_out, CT);
        release_result();

        // Slow unit: done 7 cycles after each enable
        do_reset();
        unit_delay = 7;
        run_enc(PT, 1000, 0, '0, cyc);
        chk("slow_completed", 128'(cyc > 0), 128'd1);
        chk("slow_ct", data_out, CT);
        @(posedge clk);
        chk("slow_no_err", 128'(err_cnt), 128'd0);
        chk("slow_en_count", 128'(en_cnt), 128'd40);
        release_result();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Control FSM that sequences one AES-128 encryption through the shared step units: SubBytes, ShiftRows, MixColumns and AddRoundKey.
- Owns the 128-bit state register and drives exactly one step unit at a time over a single enable/done step bus.
- Exports the current round index so the key schedule can present the matching round key.
- Sits between the top-level cipher wrapper (start/valid handshake) and the step-unit datapath.

Parameters:
WORD_SIZE, 8, bits per state byte
ARRAY_SIZE, 16, bytes per state; state width = WORD_SIZE*ARRAY_SIZE
NUM_ROUNDS, 10, AES rounds after the initial AddRoundKey
TIMEOUT, 16, max cycles to wait for step_done before aborting

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  request encryption of data_in; sampled only in IDLE
data_in  in  128  plaintext, latched on accepted start
ready  out  1  high in IDLE
step_sel  out  2  0=SubBytes 1=ShiftRows 2=MixColumns 3=AddRoundKey
step_en  out  1  one-cycle enable to the selected unit
step_state  out  128  state register, presented to the selected unit
round_idx  out  4  current round 0..NUM_ROUNDS, for key selection
step_result  in  128  output of the selected unit
step_done  in  1  selected unit finished; step_result valid
data_out  out  128  ciphertext, valid while out_valid
out_valid  out  1  result available
out_ready  in  1  consumer accepts data_out
err  out  1  one-cycle pulse on step timeout

Behaviour:
- Reset: state register = 0, round_idx = 0, step_sel = 3, step_en = 0, out_valid = 0, err = 0, FSM = IDLE, ready = 1.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - ready = 1.
  - On start: latch data_in; round_idx = 0; step_sel = 3; go to ISSUE.
- ISSUE:
  - step_en = 1 for exactly one cycle.
  - Clear timeout counter.
  - Go to WAIT.
- WAIT:
  - step_en = 0; timeout counter increments each cycle.
  - step_done is ignored in every state except WAIT.
  - On step_done: state register <= step_result, then advance the step:
    - round 0: ARK -> round 1, SB.
    - rounds 1..NUM_ROUNDS-1: SB -> SR -> MC -> ARK -> next round, SB.
    - round NUM_ROUNDS: SB -> SR -> ARK (MixColumns skipped) -> DONE.
    - Otherwise go to ISSUE.
  - If the counter reaches TIMEOUT without step_done:
    - Pulse err; state register unchanged; go to IDLE.
    - No out_valid is produced.
  - step_done in the same cycle the counter reaches TIMEOUT: done wins, no err.
- DONE:
  - out_valid = 1; data_out = state register, held stable.
  - On out_ready: out_valid drops next cycle; go to IDLE.
  - Holds indefinitely under backpressure.
- Step count: 1 + 4*(NUM_ROUNDS-1) + 3 = 40 steps for the defaults.
- Latency with single-cycle units (step_done one cycle after step_en): 2 cycles per step; out_valid high 81 cycles after the start-sampling edge.
- round_idx and step_sel are stable from ISSUE through the step_done capture.
- start while not in IDLE: ignored, no queuing.
- Reset mid-operation: abort immediately to reset values; any step_done arriving later in IDLE is ignored.
- data_out outside DONE: equals the state register; consumers qualify it with out_valid.

Test Plan:
- FIPS-197: real step units and key schedule; data_in=00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> data_out=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid at cycle 81.
- Sequence check: dummy unit with done after 1 cycle, result=state+1 -> step_sel trace 3,(0,1,2,3)x9,0,1,3; round_idx 0..10; data_out=data_in+40; never step_sel=2 when round_idx=10.
- Timeout: unit never asserts done on step 5 -> err pulse one cycle after TIMEOUT=16 wait cycles, FSM back to IDLE, ready=1, out_valid never set.
- Backpressure and busy: out_ready=0 for 20 cycles -> data_out and out_valid stable. Second start pulsed mid-run -> ignored; exactly one result produced.
- Reset mid-op: assert rst during round 5 WAIT -> next cycle ready=1, out_valid=0, round_idx=0. A fresh start then yields the correct FIPS-197 ciphertext.
- Slow unit: done 7 cycles after each enable -> correct ciphertext, no err; step_en pulses exactly 40 times.
